router_flit_injector: RTL and testbench
=======================================

// Module: router_flit_injector
// PURPOSE
//   Transmit side of the router input link. Turns a packet request (destination X/Y,
//   payload length) plus a stream of payload words into HEAD/BODY/TAIL flits, one per cycle.
//   Uses credit-based flow control toward the router input buffer.
//   Sits between a traffic source (NI/core) and one router input port.
// PARAMETERS
//   DATA_W   32  payload word width; flit = {type[1:0], DATA_W bits}
//   COORD_W  3   width of each destination coordinate
//   MAX_LEN  8   max payload words per packet; LEN_W = $clog2(MAX_LEN+1)
//   CREDITS  4   router input buffer depth = initial and maximum credit count
// PORTS
//   clk          in   1          single clock, all logic rising-edge
//   rst          in   1          synchronous, active-high reset
//   pkt_valid    in   1          packet request valid
//   pkt_ready    out  1          request accepted when pkt_valid & pkt_ready
//   pkt_dst_x    in   COORD_W    destination X
//   pkt_dst_y    in   COORD_W    destination Y
//   pkt_len      in   LEN_W      payload word count, legal 1..MAX_LEN
//   word_valid   in   1          payload word valid
//   word_ready   out  1          payload word taken when word_valid & word_ready
//   word_data    in   DATA_W     payload word
//   flit_valid   out  1          flit on flit_data this cycle (registered)
//   flit_data    out  DATA_W+2   [DATA_W+1:DATA_W] type: 01 HEAD, 00 BODY, 10 TAIL
//   credit_in    in   1          one buffer slot freed by the router (1-cycle pulse)
//   busy         out  1          state != IDLE
//   err_len      out  1          1-cycle pulse: illegal pkt_len rejected
//   err_credit   out  1          sticky: credit_in arrived with counter already at CREDITS
// BEHAVIOUR
//   Reset: state=IDLE, credits=CREDITS, remaining=0. All outputs 0, except pkt_ready=1.
//   flit_data=0 in reset. err_credit is cleared only by rst.
//   FSM states: IDLE, HEAD, PAYLOAD.
//   IDLE: pkt_ready=1. On accept with pkt_len in 1..MAX_LEN: latch dst/len, go to HEAD.
//     On accept with pkt_len=0 or pkt_len>MAX_LEN: err_len=1 next cycle, stay IDLE, no flit.
//   HEAD: pkt_ready=0. When credits>0: next cycle flit_valid=1 with
//     flit_data={01, zero-pad, dst_x, dst_y, len}; len is in the LSBs.
//     Then remaining=len and the FSM goes to PAYLOAD.
//     When credits=0: wait in HEAD, no flit.
//   PAYLOAD: word_ready = (credits>0). On each word handshake: next cycle flit_valid=1
//     with flit_data={type, word_data} and remaining decrements.
//     type=10 (TAIL) when remaining==1, else 00 (BODY).
//     After the TAIL handshake: next state is IDLE, and pkt_ready=1 again in the cycle
//     after the TAIL flit is emitted.
//   word_ready=0 outside PAYLOAD.
//   Latency: handshake (or HEAD issue) to flit_valid = 1 cycle. Max throughput 1 flit/cycle.
//   Minimum packet = 2 flits, HEAD + TAIL.
//   Credits: each emitted flit (issue cycle) consumes 1. Each credit_in adds 1.
//     Consume and credit_in in the same cycle: count unchanged.
//     credit_in with count=CREDITS and no consume: count stays CREDITS, err_credit set.
//     Count never goes below 0: no issue when count=0.
//   No flit is ever emitted without a credit available in its issue cycle.
//   rst mid-packet: the partial packet is abandoned (no TAIL sent), credits reload to CREDITS.
//     The upstream environment must also reset the router.
//   word_valid in IDLE/HEAD is ignored. pkt_valid outside IDLE is ignored (pkt_ready=0).
// TESTING
//   T1 reset: rst 2 cycles -> pkt_ready=1, word_ready=0, flit_valid=0, busy=0, err flags 0.
//   T2 dst=(3,5), len=2, words A5A5A5A5, 0000BEEF, credits ample:
//      -> HEAD {01,..,3,5,2}, BODY A5A5A5A5, TAIL 0000BEEF on 3 consecutive cycles;
//         pkt_ready high the next cycle.
//   T3 CREDITS=4, no credit_in, len=5 -> HEAD + 3 BODY then stall, word_ready=0.
//      One credit_in pulse -> exactly one more BODY; a second pulse -> TAIL.
//   T4 pkt_len=0, then pkt_len=9 -> err_len pulses each time, no flits, busy stays 0.
//   T5 consume and credit_in in the same cycle at count 1 -> count stays 1.
//      credit_in at count 4 -> err_credit=1 and stays 1 until rst.
//   T6 rst asserted after HEAD + 1 BODY of a len=4 packet -> IDLE next cycle,
//      credits=4, no TAIL; the next packet is sent correctly.

Source files
------------

// File: rtl/router_flit_injector_if.sv
// Link bundle shared by the traffic source, the flit injector and the router input port.
// The slave modport is the injector's view; master is the source/router side.
interface router_flit_injector_if #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 3,
  parameter int MAX_LEN = 8
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                pkt_valid;
  logic                pkt_ready;
  logic [COORD_W-1:0]  pkt_dst_x;
  logic [COORD_W-1:0]  pkt_dst_y;
  logic [LEN_W-1:0]    pkt_len;
  logic                word_valid;
  logic                word_ready;
  logic [DATA_W-1:0]   word_data;
  logic                flit_valid;
  logic [DATA_W+1:0]   flit_data;
  logic                credit_in;
  logic                busy;
  logic                err_len;
  logic                err_credit;

  modport master (
    output pkt_valid, pkt_dst_x, pkt_dst_y, pkt_len, word_valid, word_data, credit_in,
    input  pkt_ready, word_ready, flit_valid, flit_data, busy, err_len, err_credit
  );

  modport slave (
    input  pkt_valid, pkt_dst_x, pkt_dst_y, pkt_len, word_valid, word_data, credit_in,
    output pkt_ready, word_ready, flit_valid, flit_data, busy, err_len, err_credit
  );
endinterface

// File: rtl/router_flit_injector.sv
// Transmit side of a router input link: turns packet requests plus payload words into
// HEAD/BODY/TAIL flits under credit-based flow control toward the router input buffer.
module router_flit_injector #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 3,
  parameter int MAX_LEN = 8,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  router_flit_injector_if.slave link
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam int PAD_W = DATA_W - 2 * COORD_W - LEN_W;

  localparam logic [1:0]       T_HEAD   = 2'b01;
  localparam logic [1:0]       T_BODY   = 2'b00;
  localparam logic [1:0]       T_TAIL   = 2'b10;
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CRD_W-1:0] CRD_ZERO = {CRD_W{1'b0}};
  localparam logic [CRD_W-1:0] CRD_ONE  = {{(CRD_W-1){1'b0}}, 1'b1};
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAD    = 2'b01,
    PAYLOAD = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [CRD_W-1:0]   credits_r, credits_s;
  logic [LEN_W-1:0]   remaining_r, len_r;
  logic [COORD_W-1:0] dst_x_r, dst_y_r;
  logic               pkt_ready_r, word_ready_r, flit_valid_r, busy_r;
  logic               err_len_r, err_credit_r;
  logic [DATA_W+1:0]  flit_data_r, flit_next_s;
  logic               accept_s, len_ok_s, latch_s, len_bad_s;
  logic               head_issue_s, word_issue_s, consume_s, credit_ovf_s;

  // HEAD payload: destination and length packed at the bottom, length in the LSBs.
  function automatic logic [DATA_W+1:0] head_flit(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [LEN_W-1:0]   len);
    head_flit = {T_HEAD, {PAD_W{1'b0}}, x, y, len};
  endfunction

  assign accept_s = pkt_ready_r & link.pkt_valid;
  assign len_ok_s = (link.pkt_len != LEN_ZERO) && (link.pkt_len <= LEN_MAX);

  // Next-state decode and issue strobes.
  always_comb begin
    state_s      = state_r;
    latch_s      = 1'b0;
    len_bad_s    = 1'b0;
    head_issue_s = 1'b0;
    word_issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && len_ok_s) begin
          latch_s = 1'b1;
          state_s = HEAD;
        end else if (accept_s) begin
          len_bad_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      HEAD: begin
        if (credits_r != CRD_ZERO) begin
          head_issue_s = 1'b1;
          state_s      = PAYLOAD;
        end else begin
          state_s = HEAD;
        end
      end
      PAYLOAD: begin
        // word_ready_r already encodes "credit available" for this cycle.
        if (word_ready_r && link.word_valid) begin
          word_issue_s = 1'b1;
          if (remaining_r == LEN_ONE) begin
            state_s = IDLE;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Credit bookkeeping and the flit word to register.
  always_comb begin
    consume_s    = head_issue_s | word_issue_s;
    credit_ovf_s = link.credit_in & ~consume_s & (credits_r == CRD_MAX);
    credits_s    = credits_r;
    if (consume_s && !link.credit_in) begin
      credits_s = credits_r - CRD_ONE;
    end else if (!consume_s && link.credit_in && !credit_ovf_s) begin
      credits_s = credits_r + CRD_ONE;
    end else begin
      credits_s = credits_r;
    end
    flit_next_s = flit_data_r;
    if (head_issue_s) begin
      flit_next_s = head_flit(dst_x_r, dst_y_r, len_r);
    end else if (word_issue_s) begin
      flit_next_s = {(remaining_r == LEN_ONE) ? T_TAIL : T_BODY, link.word_data};
    end else begin
      flit_next_s = flit_data_r;
    end
  end

  // Control state, credit counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      credits_r    <= CRD_MAX;
      flit_valid_r <= 1'b0;
      flit_data_r  <= {(DATA_W + 2){1'b0}};
      pkt_ready_r  <= 1'b1;
      word_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      err_len_r    <= 1'b0;
      err_credit_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      credits_r    <= credits_s;
      flit_valid_r <= consume_s;
      flit_data_r  <= flit_next_s;
      pkt_ready_r  <= (state_s == IDLE);
      word_ready_r <= (state_s == PAYLOAD) && (credits_s != CRD_ZERO);
      busy_r       <= (state_s != IDLE);
      err_len_r    <= len_bad_s;
      err_credit_r <= err_credit_r | credit_ovf_s;
    end
  end

  // Packet context captured at request time; remaining counts words still owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_x_r     <= {COORD_W{1'b0}};
      dst_y_r     <= {COORD_W{1'b0}};
      len_r       <= LEN_ZERO;
      remaining_r <= LEN_ZERO;
    end else begin
      if (latch_s) begin
        dst_x_r <= link.pkt_dst_x;
        dst_y_r <= link.pkt_dst_y;
        len_r   <= link.pkt_len;
      end
      if (head_issue_s) begin
        remaining_r <= len_r;
      end else if (word_issue_s) begin
        remaining_r <= remaining_r - LEN_ONE;
      end
    end
  end

  assign link.pkt_ready  = pkt_ready_r;
  assign link.word_ready = word_ready_r;
  assign link.flit_valid = flit_valid_r;
  assign link.flit_data  = flit_data_r;
  assign link.busy       = busy_r;
  assign link.err_len    = err_len_r;
  assign link.err_credit = err_credit_r;
endmodule

// File: tb/tb_router_flit_injector.sv
// Bench for router_flit_injector: directed scenarios plus a randomized phase, all checked
// against a transaction-level scoreboard and credit-count model.
module tb_router_flit_injector;
  localparam int DATA_W  = 32;
  localparam int COORD_W = 3;
  localparam int MAX_LEN = 8;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_flit_injector_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .MAX_LEN(MAX_LEN)) lnk ();

  router_flit_injector #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .CREDITS(CREDITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .link(lnk)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] exp_q[$];
  int          flit_cyc[$];
  logic [33:0] flit_dat[$];
  int cyc = 0, rem_m = 0, cnt_m = CREDITS, flits_rx = 0, credits_ret = 0;
  int words_taken = 0, pkts_acc = 0, errlen_seen = 0;
  bit pkt_active = 1'b0, in_payload = 1'b0, err_cr_m = 1'b0, errlen_due = 1'b0;
  bit rst_prev = 1'b1, cin_prev = 1'b0;
  bit auto_cr = 1'b0, rand_pkts = 1'b0;
  int feed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at the falling edge: checks what the last rising edge produced, then records
  // the handshakes the next rising edge will perform.
  task automatic monitor();
    logic [33:0] e;
    cyc++;
    if (rst_prev) begin
      check("rst_flit_valid", lnk.flit_valid, 1'b0);
      check("rst_flit_data", lnk.flit_data, 34'd0);
      check("rst_pkt_ready", lnk.pkt_ready, 1'b1);
      check("rst_word_ready", lnk.word_ready, 1'b0);
      check("rst_busy", lnk.busy, 1'b0);
      check("rst_err_len", lnk.err_len, 1'b0);
      check("rst_err_credit", lnk.err_credit, 1'b0);
    end else begin
      if (lnk.flit_valid) begin
        flits_rx++;
        flit_cyc.push_back(cyc);
        flit_dat.push_back(lnk.flit_data);
        check("credit_safe", cnt_m > 0, 1'b1);
        if (exp_q.size() == 0) begin
          check("flit_unexpected", lnk.flit_data, 34'd0);
          check("flit_unexpected_valid", lnk.flit_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("flit_data", lnk.flit_data, e);
          if (e[33:32] == 2'b01) in_payload = 1'b1;
        end
      end
      if (cin_prev && !lnk.flit_valid && cnt_m == CREDITS) err_cr_m = 1'b1;
      else cnt_m = cnt_m - (lnk.flit_valid ? 1 : 0) + (cin_prev ? 1 : 0);
      check("err_len", lnk.err_len, errlen_due);
      if (lnk.err_len) errlen_seen++;
      check("err_credit", lnk.err_credit, err_cr_m);
      check("pkt_ready", lnk.pkt_ready, !pkt_active);
      check("busy", lnk.busy, pkt_active);
      check("word_ready", lnk.word_ready, in_payload && cnt_m > 0);
    end
    errlen_due = 1'b0;
    if (rst) begin
      exp_q.delete();
      rem_m = 0; pkt_active = 1'b0; in_payload = 1'b0; cnt_m = CREDITS;
      err_cr_m = 1'b0; flits_rx = 0; credits_ret = 0;
    end else begin
      if (lnk.pkt_valid && lnk.pkt_ready) begin
        pkts_acc++;
        if (lnk.pkt_len >= 1 && lnk.pkt_len <= MAX_LEN) begin
          exp_q.push_back({2'b01, 22'd0, lnk.pkt_dst_x, lnk.pkt_dst_y, lnk.pkt_len});
          rem_m = int'(lnk.pkt_len);
          pkt_active = 1'b1;
        end else begin
          errlen_due = 1'b1;
        end
      end
      if (lnk.word_valid && lnk.word_ready) begin
        words_taken++;
        if (rem_m == 0) begin
          check("word_extra", lnk.word_ready, 1'b0);
        end else begin
          exp_q.push_back({(rem_m == 1) ? 2'b10 : 2'b00, lnk.word_data});
          if (rem_m == 1) begin
            pkt_active = 1'b0;
            in_payload = 1'b0;
          end
          rem_m--;
        end
      end
    end
    cin_prev = lnk.credit_in;
    rst_prev = rst;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (auto_cr) begin
      if (!rst && (flits_rx - credits_ret) > 0 && $urandom_range(0, 2) != 0) begin
        lnk.credit_in = 1'b1;
        credits_ret++;
      end else begin
        lnk.credit_in = 1'b0;
      end
    end
    if (feed == 1) begin
      lnk.word_valid = 1'b1;
      lnk.word_data  = $urandom;
    end else if (feed == 2) begin
      lnk.word_valid = ($urandom_range(0, 2) != 0);
      lnk.word_data  = $urandom;
    end
    if (rand_pkts) begin
      lnk.pkt_valid = ($urandom_range(0, 3) == 0);
      lnk.pkt_dst_x = 3'($urandom);
      lnk.pkt_dst_y = 3'($urandom);
      lnk.pkt_len   = 4'($urandom_range(0, 10));
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    lnk.credit_in  = 1'b0;
    lnk.pkt_valid  = 1'b0;
    lnk.word_valid = 1'b0;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] x, input logic [2:0] y, input logic [3:0] len);
    int tgt = pkts_acc + 1;
    int n = 0;
    lnk.pkt_valid = 1'b1;
    lnk.pkt_dst_x = x;
    lnk.pkt_dst_y = y;
    lnk.pkt_len   = len;
    while (pkts_acc < tgt && n < 100) begin
      tick();
      n++;
    end
    check("pkt_accept_timeout", pkts_acc >= tgt, 1'b1);
    lnk.pkt_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int tgt = words_taken + 1;
    int n = 0;
    lnk.word_valid = 1'b1;
    lnk.word_data  = d;
    while (words_taken < tgt && n < 100) begin
      tick();
      n++;
    end
    check("word_accept_timeout", words_taken >= tgt, 1'b1);
    lnk.word_valid = 1'b0;
  endtask

  task automatic credit_pulse(input bit counted);
    lnk.credit_in = 1'b1;
    if (counted) credits_ret++;
    tick();
    lnk.credit_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int base_e;
    logic [33:0] last;
    lnk.pkt_valid = 1'b0; lnk.pkt_dst_x = 3'd0; lnk.pkt_dst_y = 3'd0; lnk.pkt_len = 4'd0;
    lnk.word_valid = 1'b0; lnk.word_data = 32'd0; lnk.credit_in = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset values
    do_reset(2);
    tick();
    check("t1_pkt_ready", lnk.pkt_ready, 1'b1);
    check("t1_word_ready", lnk.word_ready, 1'b0);
    check("t1_flit_valid", lnk.flit_valid, 1'b0);
    check("t1_busy", lnk.busy, 1'b0);
    check("t1_errs", {lnk.err_len, lnk.err_credit}, 2'b00);

    // T2: back-to-back HEAD/BODY/TAIL
    auto_cr = 1'b1;
    base = flit_cyc.size();
    send_pkt(3'd3, 3'd5, 4'd2);
    send_word(32'hA5A5_A5A5);
    send_word(32'h0000_BEEF);
    cycles(2);
    check("t2_nflits", flit_cyc.size() - base, 3);
    if (flit_cyc.size() - base == 3) begin
      check("t2_head", flit_dat[base], {2'b01, 22'd0, 3'd3, 3'd5, 4'd2});
      check("t2_body", flit_dat[base+1], {2'b00, 32'hA5A5_A5A5});
      check("t2_tail", flit_dat[base+2], {2'b10, 32'h0000_BEEF});
      check("t2_consecutive", flit_cyc[base+2] - flit_cyc[base], 2);
    end
    check("t2_pkt_ready", lnk.pkt_ready, 1'b1);

    // T3: credit stall and resume
    do_reset(1);
    auto_cr = 1'b0;
    feed = 1;
    send_pkt(3'd1, 3'd2, 4'd5);
    cycles(10);
    check("t3_stall_flits", flits_rx, 4);
    check("t3_stall_wready", lnk.word_ready, 1'b0);
    credit_pulse(1'b1);
    cycles(5);
    check("t3_one_more", flits_rx, 5);
    last = flit_dat[flit_dat.size()-1];
    check("t3_body_type", last[33:32], 2'b00);
    credit_pulse(1'b1);
    cycles(5);
    check("t3_tail_flits", flits_rx, 6);
    last = flit_dat[flit_dat.size()-1];
    check("t3_tail_type", last[33:32], 2'b10);
    check("t3_idle", lnk.busy, 1'b0);
    feed = 0;
    lnk.word_valid = 1'b0;
    auto_cr = 1'b1;
    cycles(20);

    // T4: illegal lengths
    base_e = errlen_seen;
    base = flit_cyc.size();
    send_pkt(3'd0, 3'd0, 4'd0);
    cycles(2);
    send_pkt(3'd7, 3'd7, 4'd9);
    cycles(2);
    check("t4_err_pulses", errlen_seen - base_e, 2);
    check("t4_no_flits", flit_cyc.size() - base, 0);
    check("t4_busy", lnk.busy, 1'b0);

    // T5: coincident consume+credit at count 1, then overflow credit
    do_reset(1);
    auto_cr = 1'b0;
    send_pkt(3'd2, 3'd2, 4'd2);
    send_word($urandom);
    send_word($urandom);
    cycles(3);
    lnk.pkt_dst_x = 3'd6; lnk.pkt_dst_y = 3'd1; lnk.pkt_len = 4'd1;
    lnk.pkt_valid = 1'b1;
    tick();
    lnk.pkt_valid = 1'b0;
    credit_pulse(1'b1);
    tick();
    check("t5_coincide_wready", lnk.word_ready, 1'b1);
    send_word($urandom);
    cycles(2);
    credit_pulse(1'b1);
    tick();
    send_pkt(3'd1, 3'd1, 4'd1);
    cycles(3);
    check("t5_empty_wready", lnk.word_ready, 1'b0);
    check("t5_flits", flits_rx, 6);
    check("t5_busy", lnk.busy, 1'b1);
    auto_cr = 1'b1;
    send_word($urandom);
    cycles(20);
    auto_cr = 1'b0;
    lnk.credit_in = 1'b0;
    credit_pulse(1'b0);
    tick();
    check("t5_err_credit", lnk.err_credit, 1'b1);
    cycles(4);
    check("t5_err_sticky", lnk.err_credit, 1'b1);

    // T6: reset mid-packet
    do_reset(2);
    tick();
    check("t6_err_cleared", lnk.err_credit, 1'b0);
    auto_cr = 1'b1;
    send_pkt(3'd4, 3'd3, 4'd4);
    send_word($urandom);
    cycles(3);
    check("t6_pre_flits", flits_rx, 2);
    do_reset(1);
    cycles(5);
    check("t6_no_tail", flits_rx, 0);
    check("t6_idle", lnk.busy, 1'b0);
    auto_cr = 1'b0;
    lnk.credit_in = 1'b0;
    feed = 1;
    send_pkt(3'd5, 3'd6, 4'd3);
    cycles(8);
    check("t6_next_flits", flits_rx, 4);
    check("t6_next_done", lnk.busy, 1'b0);
    feed = 0;
    lnk.word_valid = 1'b0;
    auto_cr = 1'b1;
    cycles(10);

    // Randomized traffic, then drain
    rand_pkts = 1'b1;
    feed = 2;
    cycles(600);
    rand_pkts = 1'b0;
    lnk.pkt_valid = 1'b0;
    feed = 1;
    cycles(80);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", lnk.busy, 1'b0);
    feed = 0;
    lnk.word_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
